// File: rtl/tone_detector.sv
// tone_detector: measures the rising-edge period of an asynchronous square wave and
// classifies it as tone 1, tone 2 or none. A tone is reported only after MATCH_N
// consecutive periods of the same class; no edge for TIMEOUT cycles reports silence.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tone_in      asynchronous square-wave input
//   tone_id      0 = none, 1 = tone 1, 2 = tone 2 (3 never driven)
//   locked       high while tone_id is nonzero
//   period       last measured period in clk cycles
//   tone_change  one-cycle pulse in the cycle tone_id takes a new value
//   led9         copy of locked
module tone_detector #(
  parameter int unsigned IN_CLK    = 50000000,
  parameter int unsigned F1        = 1000,
  parameter int unsigned F2        = 8000,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned MATCH_N   = 4,
  parameter int unsigned TIMEOUT   = 4 * (IN_CLK / F1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [1:0]  tone_id,
  output logic        locked,
  output logic [26:0] period,
  output logic        tone_change,
  output logic        led9
);

  // Full periods mirror the generator, which toggles every IN_CLK/Fn cycles.
  localparam logic [26:0] P1        = 27'(2 * (IN_CLK / F1));
  localparam logic [26:0] P2        = 27'(2 * (IN_CLK / F2));
  localparam logic [26:0] TOL1      = P1 >> TOL_SHIFT;
  localparam logic [26:0] TOL2      = P2 >> TOL_SHIFT;
  localparam logic [26:0] TMO       = 27'(TIMEOUT);
  localparam logic [3:0]  MATCH_LIM = 4'(MATCH_N);

  localparam logic [1:0] StSilent  = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  logic        s1_q, s2_q, s3_q;
  logic        rise;
  logic [26:0] cnt_q, cnt_d;
  logic [26:0] period_q, period_d;
  logic [26:0] meas;
  logic [1:0]  state_q, state_d;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  tone_q, tone_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  match_inc;
  logic [1:0]  cls;
  logic        timeout;
  logic        change_q;

  function automatic logic [26:0] abs_diff(input logic [26:0] a, input logic [26:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  // cnt counts cycles since the previous edge, so the period ending now is cnt+1.
  assign meas    = cnt_q + 27'd1;
  assign timeout = (cnt_q == TMO);

  // Tone 1 is checked first so it wins if the two tolerance windows overlap.
  always_comb begin
    cls = 2'd0;
    if (abs_diff(meas, P1) <= TOL1) begin
      cls = 2'd1;
    end else if (abs_diff(meas, P2) <= TOL2) begin
      cls = 2'd2;
    end
  end

  always_comb begin
    cnt_d = rise ? 27'd0 : (timeout ? cnt_q : meas);
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    match_d   = match_q;
    tone_d    = tone_q;
    period_d  = period_q;
    match_inc = match_q + 4'd1;
    // An edge in the timeout cycle takes priority over the timeout.
    if (rise) begin
      case (state_q)
        StSilent: begin
          // First edge only re-arms; there is no valid reference yet.
          state_d = StAcquire;
          cand_d  = 2'd0;
          match_d = 4'd0;
        end
        StAcquire: begin
          period_d = meas;
          if (cls == 2'd0) begin
            match_d = 4'd0;
          end else if (cls == cand_q) begin
            match_d = match_inc;
          end else begin
            cand_d  = cls;
            match_d = 4'd1;
          end
          if ((cls != 2'd0) && (match_d == MATCH_LIM)) begin
            state_d = StLocked;
            tone_d  = cls;
          end
        end
        StLocked: begin
          period_d = meas;
          if (cls != tone_q) begin
            state_d = StAcquire;
            tone_d  = 2'd0;
            if (cls != 2'd0) begin
              cand_d  = cls;
              match_d = 4'd1;
            end else begin
              match_d = 4'd0;
            end
          end
        end
        default: begin
          state_d = StSilent;
          tone_d  = 2'd0;
        end
      endcase
    end else if (timeout) begin
      state_d = StSilent;
      tone_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 27'd0;
      period_q <= 27'd0;
      state_q  <= StSilent;
      cand_q   <= 2'd0;
      match_q  <= 4'd0;
      tone_q   <= 2'd0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      tone_q   <= tone_d;
      change_q <= (tone_d != tone_q);
    end
  end

  assign tone_id     = tone_q;
  assign locked      = (tone_q != 2'd0);
  assign led9        = locked;
  assign period      = period_q;
  assign tone_change = change_q;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector with a small-parameter build (P1=200, P2=40, TIMEOUT=400).
// An event-level reference model tracks edge times, measured periods and match runs.
module tb_tone_detector;

  localparam int unsigned IN_CLK = 1000;
  localparam int unsigned F1     = 10;
  localparam int unsigned F2     = 50;
  localparam int unsigned TS     = 3;
  localparam int unsigned MN     = 3;
  localparam int unsigned TMO    = 400;
  localparam int P1   = 200;
  localparam int P2   = 40;
  localparam int TOL1 = 25;
  localparam int TOL2 = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic [1:0]  tone_id;
  logic        locked;
  logic [26:0] period;
  logic        tone_change;
  logic        led9;

  tone_detector #(
    .IN_CLK   (IN_CLK),
    .F1       (F1),
    .F2       (F2),
    .TOL_SHIFT(TS),
    .MATCH_N  (MN),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .tone_id    (tone_id),
    .locked     (locked),
    .period     (period),
    .tone_change(tone_change),
    .led9       (led9)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses = 0;
  bit rst_req = 1'b1;

  // Reference model state
  bit h[3];
  bit armed = 1'b0;
  int last_e = 0;
  int cand = 0;
  int run = 0;
  int m_tone = 0;
  int m_period = 0;
  bit m_chg = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int classify(input int p);
    int d1;
    int d2;
    d1 = (p > P1) ? p - P1 : P1 - p;
    d2 = (p > P2) ? p - P2 : P2 - p;
    if (d1 <= TOL1) return 1;
    if (d2 <= TOL2) return 2;
    return 0;
  endfunction

  // One clock: drive at negedge, update the model at posedge, compare 1 time unit later.
  task automatic tick(input bit lvl);
    bit e;
    int since;
    int p;
    int c;
    int prev;
    @(negedge clk);
    tone_in = lvl;
    rst = rst_req;
    @(posedge clk);
    cyc++;
    if (rst) begin
      h = '{default: 1'b0};
      armed = 1'b0;
      last_e = cyc;
      cand = 0;
      run = 0;
      m_tone = 0;
      m_period = 0;
      m_chg = 1'b0;
    end else begin
      // h[k] is the first synchronizer stage k clocks ago; rise seen 2 clocks after sampling.
      e = h[1] && !h[2];
      h[2] = h[1];
      h[1] = h[0];
      h[0] = lvl;
      prev = m_tone;
      since = cyc - last_e;
      if (e) begin
        if (!armed) begin
          armed = 1'b1;
          cand = 0;
          run = 0;
        end else begin
          p = (since > int'(TMO) + 1) ? int'(TMO) + 1 : since;
          m_period = p;
          c = classify(p);
          if (m_tone != 0) begin
            if (c != m_tone) begin
              m_tone = 0;
              if (c != 0) begin
                cand = c;
                run = 1;
              end else begin
                run = 0;
              end
            end
          end else begin
            if (c == 0) run = 0;
            else if (c == cand) run++;
            else begin
              cand = c;
              run = 1;
            end
            if (c != 0 && run == int'(MN)) m_tone = c;
          end
        end
        last_e = cyc;
      end else if (since >= int'(TMO) + 1) begin
        armed = 1'b0;
        m_tone = 0;
      end
      m_chg = (m_tone != prev);
    end
    #1;
    if (tone_change === 1'b1) pulses++;
    check("outputs", 64'({tone_id, locked, tone_change, led9, period}),
          64'({m_tone[1:0], m_tone != 0, m_chg, m_tone != 0, m_period[26:0]}));
  endtask

  task automatic wave(input int per, input int high);
    for (int i = 0; i < per; i++) tick(i < high);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0);
  endtask

  initial begin
    int kind;
    int base;
    int per;
    int len;
    h = '{default: 1'b0};

    // Reset state
    rst_req = 1'b1;
    repeat (3) tick(1'b0);
    check("reset tone_id", 64'(tone_id), 64'd0);
    check("reset locked", 64'(locked), 64'd0);
    check("reset period", 64'(period), 64'd0);
    check("reset tone_change", 64'(tone_change), 64'd0);
    check("reset led9", 64'(led9), 64'd0);
    rst_req = 1'b0;
    idle(5);

    // Lock tone 1
    pulses = 0;
    repeat (6) wave(200, int'($urandom_range(20, 180)));
    check("t1 tone_id", 64'(tone_id), 64'd1);
    check("t1 locked", 64'(locked), 64'd1);
    check("t1 led9", 64'(led9), 64'd1);
    check("t1 period", 64'(period), 64'd200);
    check("t1 change pulses", 64'(pulses), 64'd1);

    // Asynchronous reset mid-measurement with tone_in toggling
    for (int i = 0; i < 30; i++) tick(((i / 7) % 2) == 0);
    #2;
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    check("async rst tone_id", 64'(tone_id), 64'd0);
    check("async rst locked", 64'(locked), 64'd0);
    check("async rst period", 64'(period), 64'd0);
    check("async rst led9", 64'(led9), 64'd0);
    for (int i = 0; i < 4; i++) tick(i[0]);
    rst_req = 1'b0;
    wave(200, 100);
    wave(200, 100);
    check("post-rst locked", 64'(locked), 64'd0);
    check("post-rst tone_id", 64'(tone_id), 64'd0);
    repeat (3) wave(200, 100);
    check("relock tone_id", 64'(tone_id), 64'd1);

    // Tone 2 at the tolerance edges
    idle(450);
    wave(44, 22);
    wave(36, 18);
    wave(45, 20);
    wave(40, 20);
    idle(10);
    check("t2 tol tone_id", 64'(tone_id), 64'd2);
    check("t2 tol period", 64'(period), 64'd45);

    // Period 46 is just outside tolerance
    idle(450);
    pulses = 0;
    repeat (6) wave(46, 23);
    idle(10);
    check("p46 tone_id", 64'(tone_id), 64'd0);
    check("p46 pulses", 64'(pulses), 64'd0);

    // Tone switch 1 -> 0 -> 2
    idle(450);
    repeat (5) wave(200, 100);
    check("sw pre tone_id", 64'(tone_id), 64'd1);
    pulses = 0;
    repeat (2) wave(40, 20);
    check("sw drop tone_id", 64'(tone_id), 64'd0);
    repeat (2) wave(40, 20);
    check("sw lock tone_id", 64'(tone_id), 64'd2);
    check("sw pulses", 64'(pulses), 64'd2);

    // Silence after lock: period retained, next edge only re-arms
    idle(450);
    repeat (5) wave(200, 100);
    pulses = 0;
    idle(450);
    check("sil tone_id", 64'(tone_id), 64'd0);
    check("sil locked", 64'(locked), 64'd0);
    check("sil period", 64'(period), 64'd200);
    check("sil pulses", 64'(pulses), 64'd1);
    wave(200, 100);
    check("rearm period", 64'(period), 64'd200);

    // Alternating near-miss periods never lock
    pulses = 0;
    repeat (3) begin
      wave(120, 60);
      wave(200, 100);
    end
    idle(5);
    check("alt locked", 64'(locked), 64'd0);
    check("alt pulses", 64'(pulses), 64'd0);

    // Randomized runs against the model
    repeat (40) begin
      kind = int'($urandom_range(0, 4));
      len = int'($urandom_range(1, 6));
      if (kind == 4) begin
        idle(int'($urandom_range(300, 500)));
      end else begin
        base = (kind == 0 || kind == 3) ? P1 : (kind == 1 ? P2 : 0);
        repeat (len) begin
          if (base == P1) per = base + int'($urandom_range(0, 60)) - 30;
          else if (base == P2) per = base + int'($urandom_range(0, 14)) - 7;
          else per = int'($urandom_range(2, 450));
          wave(per, int'($urandom_range(1, per - 1)));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
